// File: rtl/cla_wide_seq.sv
// ---------------------------------------------------------------------------
// cla_wide_seq
//   Multi-byte add/subtract sequencer that time-shares one external 8-bit
//   carry-lookahead adder. A request carries two NBYTES-wide operands. They
//   are pushed through the adder one byte per cycle, LSB first, and each
//   byte's carry-out is chained into the next byte's carry-in. The wide result
//   is returned with the final carry and two's-complement overflow.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready=1, adder inputs held at 0, waiting for a request
//   RUN   | one byte per cycle through the adder, NBYTES cycles
//   DONE  | out_valid=1, result held until the consumer takes it
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_a, in_b, in_sub    operands (W bits) and op select (1 = A-B)
//   add_a/add_b/add_cin   drive the shared 8-bit adder
//   add_sum/add_cout      combinational adder result
//   out_valid/out_ready   result handshake
//   out_result            A+B or A-B modulo 2^W
//   out_cout              final carry-out (subtract: 1 = no borrow)
//   out_ovf               signed overflow
// ---------------------------------------------------------------------------
module cla_wide_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_sub,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_result,
    output logic                out_cout,
    output logic                out_ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic            carry_q,  carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q,   cout_d;
    logic            ovf_q,    ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        out_valid = 1'b0;
        add_a    = 8'h00;
        add_b    = 8'h00;
        add_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtract as A + ~B + 1: B is stored inverted and the
                    // +1 enters as the carry into byte 0.
                    a_d     = in_a;
                    b_d     = in_b ^ {W{in_sub}};
                    carry_d = in_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                add_a   = a_q[8*idx_q +: 8];
                add_b   = b_q[8*idx_q +: 8];
                add_cin = carry_q;
                result_d[8*idx_q +: 8] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    // Overflow: operands share a sign that the result lacks.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_sum[7] != a_q[W-1]);
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_cla_wide_seq.sv
module tb_cla_wide_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_cout;
    logic        out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared 8-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    cla_wide_seq #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_result;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE, checks the per-byte adder drive against a
    // byte-serial model and that out_valid first appears in the 5th cycle after
    // the accept cycle, then checks the result. Leaves the DUT in DONE.
    task automatic run_op(input vec_t v);
        int          cyc;
        logic [31:0] av;
        logic [31:0] bx;
        logic        c;
        logic [8:0]  s9;
        av = v.a;
        bx = v.b ^ {32{v.sub}};
        c  = v.sub;
        in_a = v.a; in_b = v.b; in_sub = v.sub; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b; in_sub = ~v.sub;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            if (cyc <= 4) begin
                chk("add_a", add_a, av[8*(cyc-1) +: 8]);
                chk("add_b", add_b, bx[8*(cyc-1) +: 8]);
                chk("add_cin", add_cin, c);
                s9 = {1'b0, av[8*(cyc-1) +: 8]} + {1'b0, bx[8*(cyc-1) +: 8]} + {8'h00, c};
                c  = s9[8];
            end
            chk("in_ready_run", in_ready, 0);
            tick();
            cyc++;
        end
        chk("latency", cyc, 5);
        chk("result", out_result, v.exp_result);
        chk("cout", out_cout, v.exp_cout);
        chk("ovf", out_ovf, v.exp_ovf);
        chk("in_ready_done", in_ready, 0);
        chk("add_a_done", add_a, 0);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_in_ready", in_ready, 1);
        chk("hs_out_valid", out_valid, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_cout", out_cout, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
            take_result();
        end

        // Consumer stalls 3 cycles in DONE while a new request is offered.
        run_op(vecs[5]);
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D; in_sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_result", out_result, 32'h7FFF_FFFF);
            chk("stall_cout", out_cout, 1);
            chk("stall_ovf", out_ovf, 1);
        end
        in_valid = 1'b0;
        take_result();
        tick();
        chk("post_stall_idle", in_ready, 1);

        // Reset while byte 2 is in the adder: op is dropped.
        in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_add_a", add_a, 8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", out_result, 0);
        chk("abort_add_a", add_a, 0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("abort_no_valid", seen, 0);
        end
        run_op(vecs[6]);
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
